// File: rtl/gf_pkg.sv
// ---------------------------------------------------------------------------
// gf_pkg : shared state, op encodings and POLY legality check for gf_mul_seq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package gf_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_INV  = 2'd2,
    S_DONE = 2'd3
  } gf_state_e;

  localparam logic [1:0] ST_IDLE = S_IDLE;
  localparam logic [1:0] ST_MUL  = S_MUL;
  localparam logic [1:0] ST_INV  = S_INV;
  localparam logic [1:0] ST_DONE = S_DONE;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_INV = 1'b1;

  // The reduction polynomial must be monic of degree m.
  function automatic logic gf_poly_legal(input int m, input logic [16:0] poly);
    return poly[m];
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf_mul_step.sv
// ---------------------------------------------------------------------------
// gf_mul_step : one MSB-first shift-and-add step of a GF(2^M) multiply
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gf_mul_step #(
  parameter int           M    = 4,
  parameter logic [M:0]   POLY = 5'b10011
) (
  input  logic [M-1:0] acc_i,
  input  logic [M-1:0] a_i,
  input  logic         bit_i,
  output logic [M-1:0] acc_o
);

  assign acc_o = {acc_i[M-2:0], 1'b0}
               ^ (acc_i[M-1] ? POLY[M-1:0] : '0)
               ^ (bit_i ? a_i : '0);

endmodule

`default_nettype wire

// File: rtl/gf_mul_seq.sv
// ---------------------------------------------------------------------------
// gf_mul_seq : bit-serial GF(2^M) multiply, plus inverse when GF_INV_EN is set
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gf_mul_seq
  import gf_pkg::*;
#(
  parameter int         M    = 4,
  parameter logic [M:0] POLY = 5'b10011
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         out_err
);

  localparam int             CW         = (M > 2) ? $clog2(M) : 1;
  localparam logic [CW-1:0]  C_CNT_LAST = CW'(M - 1);

  generate
    if (M < 2 || M > 16 || !gf_poly_legal(M, 17'(POLY))) begin : g_bad_param
      $error("gf_mul_seq: M must be 2..16 and POLY[M] must be 1");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [M-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  w_step_a, w_step_out;
  logic          w_step_bit;

`ifdef GF_INV_EN
  // a_q doubles as the running square and b_q as the running product.
  logic          phase_q, phase_d;
  logic [CW-1:0] k_q, k_d;
  logic          err_q, err_d;
`else
  logic          w_unused_op;
  assign w_unused_op = in_op;
`endif

  always_comb begin
    w_step_a   = a_q;
    w_step_bit = b_q[cnt_q];
`ifdef GF_INV_EN
    if (state_q == ST_INV) begin
      w_step_a   = phase_q ? b_q : a_q;
      w_step_bit = a_q[cnt_q];
    end
`endif
  end

  gf_mul_step #(.M(M), .POLY(POLY)) u_step (
    .acc_i (acc_q),
    .a_i   (w_step_a),
    .bit_i (w_step_bit),
    .acc_o (w_step_out)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef GF_INV_EN
    phase_d = phase_q;
    k_d     = k_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          cnt_d   = C_CNT_LAST;
          state_d = ST_MUL;
`ifdef GF_INV_EN
          err_d = (in_op == OP_INV) && (in_a == '0);
          if (in_op == OP_INV) begin
            b_d     = M'(1);
            phase_d = 1'b0;
            k_d     = CW'(1);
            state_d = ST_INV;
          end
`endif
        end
      end
      ST_MUL: begin
        acc_d = w_step_out;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          data_d  = w_step_out;
          state_d = ST_DONE;
        end
      end
`ifdef GF_INV_EN
      ST_INV: begin
        acc_d = w_step_out;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          acc_d = '0;
          cnt_d = C_CNT_LAST;
          if (!phase_q) begin
            a_d     = w_step_out;
            phase_d = 1'b1;
          end else begin
            b_d     = w_step_out;
            phase_d = 1'b0;
            k_d     = k_q + CW'(1);
            if (k_q == CW'(M - 1)) begin
              data_d  = w_step_out;
              state_d = ST_DONE;
            end
          end
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef GF_INV_EN
      phase_q <= 1'b0;
      k_q     <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef GF_INV_EN
      phase_q <= phase_d;
      k_q     <= k_d;
      err_q   <= err_d;
`endif
    end
  end

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;
`ifdef GF_INV_EN
  assign out_err   = err_q;
`else
  assign out_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gf_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_gf_mul_seq : directed checks of gf_mul_seq at M=4 (0x13) and M=8 (0x11B)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gf_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v4_valid, v4_op, v4_ordy;
  logic [3:0] v4_a, v4_b;
  logic       r4_rdy, o4_valid, o4_err;
  logic [3:0] o4_data;
  logic       v8_valid, v8_op, v8_ordy;
  logic [7:0] v8_a, v8_b;
  logic       r8_rdy, o8_valid, o8_err;
  logic [7:0] o8_data;

  int tests = 0;
  int fails = 0;

  gf_mul_seq #(.M(4), .POLY(5'h13)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4_valid), .in_ready(r4_rdy),
    .in_op(v4_op), .in_a(v4_a), .in_b(v4_b), .out_valid(o4_valid),
    .out_ready(v4_ordy), .out_data(o4_data), .out_err(o4_err)
  );

  gf_mul_seq #(.M(8), .POLY(9'h11B)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8_valid), .in_ready(r8_rdy),
    .in_op(v8_op), .in_a(v8_a), .in_b(v8_b), .out_valid(o8_valid),
    .out_ready(v8_ordy), .out_data(o8_data), .out_err(o8_err)
  );

  // Presents one request, scrambles the operands after accept, and waits for out_valid.
  task automatic issue(input bit wide, input logic op, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic [7:0] data, output logic err);
    int w = 0;
    @(negedge clk);
    while (!(wide ? r8_rdy : r4_rdy) && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (wide) begin
      v8_valid = 1'b1; v8_op = op; v8_a = a; v8_b = b;
    end else begin
      v4_valid = 1'b1; v4_op = op; v4_a = a[3:0]; v4_b = b[3:0];
    end
    @(posedge clk); #1;
    v4_valid = 1'b0; v8_valid = 1'b0;
    v4_a = ~v4_a; v4_b = ~v4_b; v8_a = ~v8_a; v8_b = ~v8_b; v4_op = ~v4_op; v8_op = ~v8_op;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (wide ? o8_valid : o4_valid) begin
        lat = i;
        break;
      end
    end
    data = wide ? o8_data : {4'h0, o4_data};
    err  = wide ? o8_err : o4_err;
  endtask

  task automatic drain(input bit wide);
    if (wide) v8_ordy = 1'b1; else v4_ordy = 1'b1;
    @(posedge clk); #1;
    v4_ordy = 1'b0; v8_ordy = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    v4_valid = 0; v4_op = 0; v4_a = 0; v4_b = 0; v4_ordy = 0;
    v8_valid = 0; v8_op = 0; v8_a = 0; v8_b = 0; v8_ordy = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (r4_rdy !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b want=0", r4_rdy); end
    tests++; if (o4_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", o4_valid); end
    tests++; if (o4_data !== 4'h0) begin fails++; $display("FAIL reset_out_data got=%h want=0", o4_data); end
    tests++; if (o4_err !== 1'b0) begin fails++; $display("FAIL reset_out_err got=%b want=0", o4_err); end
    tests++; if (o8_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid8 got=%b want=0", o8_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (r4_rdy !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%b want=1", r4_rdy); end
  endtask

  task automatic test_mul;
    logic [3:0] vec [4][3] = '{'{4'h2, 4'h3, 4'h6}, '{4'h9, 4'hE, 4'h7},
                                '{4'h0, 4'h5, 4'h0}, '{4'h7, 4'h7, 4'h6}};
    int lat; logic [7:0] d; logic e;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b0, {4'h0, vec[i][0]}, {4'h0, vec[i][1]}, lat, d, e);
      tests++; if (d !== {4'h0, vec[i][2]}) begin fails++; $display("FAIL mul4[%0d] data got=%h want=%h", i, d, vec[i][2]); end
      tests++; if (lat !== 4) begin fails++; $display("FAIL mul4[%0d] latency got=%0d want=4", i, lat); end
      tests++; if (e !== 1'b0) begin fails++; $display("FAIL mul4[%0d] err got=%b want=0", i, e); end
      drain(1'b0);
    end
  endtask

  task automatic test_mul8;
    int lat; logic [7:0] d; logic e;
    issue(1'b1, 1'b0, 8'h57, 8'h83, lat, d, e);
    tests++; if (d !== 8'hC1) begin fails++; $display("FAIL mul8 data got=%h want=c1", d); end
    tests++; if (lat !== 8) begin fails++; $display("FAIL mul8 latency got=%0d want=8", lat); end
    drain(1'b1);
  endtask

  task automatic test_inverse;
    int lat; logic [7:0] d; logic e;
`ifdef GF_INV_EN
    logic [3:0] vec [3][3] = '{'{4'h2, 4'h9, 4'h0}, '{4'hF, 4'h8, 4'h0}, '{4'h0, 4'h0, 4'h1}};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, {4'h0, vec[i][0]}, 8'h0B, lat, d, e);
      tests++; if (d !== {4'h0, vec[i][1]}) begin fails++; $display("FAIL inv4[%0d] data got=%h want=%h", i, d, vec[i][1]); end
      tests++; if (lat !== 24) begin fails++; $display("FAIL inv4[%0d] latency got=%0d want=24", i, lat); end
      tests++; if (e !== vec[i][2][0]) begin fails++; $display("FAIL inv4[%0d] err got=%b want=%b", i, e, vec[i][2][0]); end
      drain(1'b0);
    end
    issue(1'b1, 1'b1, 8'h53, 8'h00, lat, d, e);
    tests++; if (d !== 8'hCA) begin fails++; $display("FAIL inv8 data got=%h want=ca", d); end
    tests++; if (lat !== 112) begin fails++; $display("FAIL inv8 latency got=%0d want=112", lat); end
    drain(1'b1);
`else
    issue(1'b0, 1'b1, 8'h02, 8'h03, lat, d, e);
    tests++; if (d !== 8'h06) begin fails++; $display("FAIL op_ignored data got=%h want=06", d); end
    tests++; if (lat !== 4) begin fails++; $display("FAIL op_ignored latency got=%0d want=4", lat); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL op_ignored err got=%b want=0", e); end
    drain(1'b0);
    issue(1'b0, 1'b1, 8'h00, 8'h05, lat, d, e);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL op_ignored_zero err got=%b want=0", e); end
    drain(1'b0);
`endif
  endtask

  task automatic test_backpressure;
    int lat; logic [7:0] d; logic e;
    bit stable = 1'b1;
    bit rdy_low = 1'b1;
    issue(1'b0, 1'b0, 8'h09, 8'h0E, lat, d, e);
    v4_valid = 1'b1; v4_op = 1'b0; v4_a = 4'h2; v4_b = 4'h3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (o4_valid !== 1'b1 || o4_data !== 4'h7) stable = 1'b0;
      if (r4_rdy !== 1'b0) rdy_low = 1'b0;
    end
    tests++; if (!stable) begin fails++; $display("FAIL bp_hold last valid=%b data=%h want valid=1 data=7", o4_valid, o4_data); end
    tests++; if (!rdy_low) begin fails++; $display("FAIL bp_in_ready got=%b want=0 throughout", r4_rdy); end
    v4_ordy = 1'b1;
    @(posedge clk); #1;
    v4_ordy = 1'b0;
    tests++; if (o4_valid !== 1'b0) begin fails++; $display("FAIL bp_release valid got=%b want=0", o4_valid); end
    tests++; if (r4_rdy !== 1'b1) begin fails++; $display("FAIL bp_release in_ready got=%b want=1", r4_rdy); end
    @(posedge clk); #1;
    v4_valid = 1'b0;
    tests++; if (r4_rdy !== 1'b0) begin fails++; $display("FAIL bp_next_accept in_ready got=%b want=0", r4_rdy); end
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if (o4_valid) begin lat = i; break; end
    end
    tests++; if (lat !== 4 || o4_data !== 4'h6) begin fails++; $display("FAIL bp_next_result lat=%0d data=%h want lat=4 data=6", lat, o4_data); end
    drain(1'b0);
  endtask

  task automatic test_reset_mid;
    int lat; logic [7:0] d; logic e;
    int abort_at;
    bit quiet = 1'b1;
`ifdef GF_INV_EN
    abort_at = 5;
`else
    abort_at = 2;
`endif
    @(negedge clk);
    v4_valid = 1'b1; v4_op = 1'b1; v4_a = 4'h2; v4_b = 4'h3;
    @(posedge clk); #1;
    v4_valid = 1'b0;
    for (int i = 0; i < abort_at; i++) begin
      @(posedge clk); #1;
      if (o4_valid !== 1'b0) quiet = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (o4_valid !== 1'b0) quiet = 1'b0;
    end
    tests++; if (r4_rdy !== 1'b0) begin fails++; $display("FAIL midrst in_ready got=%b want=0", r4_rdy); end
    tests++; if (o4_data !== 4'h0) begin fails++; $display("FAIL midrst out_data got=%h want=0", o4_data); end
    tests++; if (o4_err !== 1'b0) begin fails++; $display("FAIL midrst out_err got=%b want=0", o4_err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (o4_valid !== 1'b0) quiet = 1'b0;
    end
    tests++; if (!quiet) begin fails++; $display("FAIL midrst out_valid rose got=1 want=0"); end
    issue(1'b0, 1'b0, 8'h07, 8'h07, lat, d, e);
    tests++; if (d !== 8'h06 || lat !== 4) begin fails++; $display("FAIL midrst_after data=%h lat=%0d want data=06 lat=4", d, lat); end
    drain(1'b0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul8();
    test_inverse();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
